sram_port_arbiter: RTL and testbench
====================================

Name: sram_port_arbiter

Overview:
- Shares one single-port SRAM macro (prim_ram_1p-style req/write/addr/wdata/wmask/rdata port) between two requesters.
- Host 0 is the tlul_adapter_sram serving the crossbar. Host 1 is a secondary master, e.g. a UART boot loader writing the program image.
- Arbitration is round-robin with single-cycle combinational grant.
- A latency-matched pipeline routes each read response back to the host that issued it.

Parameters:
- AddrWidth, 11, SRAM word address width.
- DataWidth, 32, SRAM data width.
- ReadLatency, 1, cycles from accepted read to rdata valid at the macro; legal values 1..4.
- Host0Priority, 0, when 1 host 0 always wins (fixed priority) and the round-robin pointer is ignored.

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  asynchronous active-high reset.
- h_req_i  input  2  per-host request, bit n = host n.
- h_we_i  input  2  per-host write enable.
- h_addr_i  input  2*AddrWidth  per-host word address; host n occupies slice n.
- h_wdata_i  input  2*DataWidth  per-host write data.
- h_wmask_i  input  2*DataWidth  per-host bit write mask.
- h_gnt_o  output  2  per-host grant; at most one bit set (one-hot or zero).
- h_rvalid_o  output  2  per-host read data valid.
- h_rdata_o  output  DataWidth  read data, shared by both hosts; qualified by h_rvalid_o.
- ram_req_o  output  1  SRAM request.
- ram_we_o  output  1  SRAM write.
- ram_addr_o  output  AddrWidth  SRAM address.
- ram_wdata_o  output  DataWidth  SRAM write data.
- ram_wmask_o  output  DataWidth  SRAM write mask.
- ram_rdata_i  input  DataWidth  SRAM read data.
- busy_o  output  1  a read is in flight in the response pipe.

Behaviour:
- Interface decision: single clock clk_i; reset rst_i is asynchronous and active-high.
- Reset values:
  - h_gnt_o=0, h_rvalid_o=0, h_rdata_o=0, busy_o=0.
  - ram_req_o=0, ram_we_o=0, ram_addr_o=0, ram_wdata_o=0, ram_wmask_o=0.
  - Round-robin pointer favours host 0.
  - Response pipe cleared.
- Grant (combinational, same cycle as request):
  - Only one host requesting: it is granted.
  - Both requesting: the host favoured by the pointer is granted. With Host0Priority=1, host 0 always wins.
  - No request: no grant, ram_req_o=0.
  - A transfer is accepted when h_gnt_o[n] is high. Hosts hold req and payload until granted; there is no cancellation.
- Memory drive:
  - ram_req_o = |h_gnt_o.
  - ram_we_o, ram_addr_o, ram_wdata_o, ram_wmask_o are muxed from the granted host.
  - With no grant, the payload outputs are 0.
- Pointer update:
  - On an accepted transfer by host n, the pointer moves to favour host 1-n from the next cycle.
  - No accept: pointer holds.
  - Under continuous dual requests, grants therefore alternate 0,1,0,1 and no host waits more than 1 cycle.
- Response pipe:
  - Shift register of depth ReadLatency; each entry holds {valid, owner}.
  - An accepted read (we=0) enters {1,n}. Accepted writes and idle cycles enter {0,x}.
  - Writes produce no rvalid.
  - At the pipe output: h_rvalid_o[owner]=valid and h_rdata_o=ram_rdata_i, registered-through so it is valid in the same cycle the macro presents data.
  - Example: ReadLatency=1, read accepted in cycle t gives rvalid in cycle t+1.
  - h_rdata_o=0 when no rvalid.
- Back-to-back reads from either host pipeline fully: one accept per cycle, responses in order, each tagged to its owner.
- busy_o = OR of the valid bits in the response pipe.
- Reset mid-operation: in-flight reads are discarded and no rvalid is emitted after reset. Hosts must reissue.
- Illegal ReadLatency (0 or greater than 4) fails an elaboration assertion.

Test Plan:
- Reset, then host 0 read addr 0x010 with the RAM preloaded to 0xDEADBEEF -> gnt[0] in the request cycle; ram_addr_o=0x010; rvalid[0]=1 with rdata 0xDEADBEEF exactly 1 cycle later; rvalid[1] stays 0.
- Both hosts hold read requests for 4 cycles (host0 addr 0x1, host1 addr 0x2) -> grants 0,1,0,1; rvalid pattern 0,1,0,1 delayed by one cycle, with the matching data each time.
- Host 1 writes 0x12345678 with wmask 0x0000FFFF to 0x7FF, then reads 0x7FF (prior content 0xAAAAAAAA) -> no rvalid for the write; the read returns 0xAAAA5678.
- Host0Priority=1 with both requesting continuously for 5 cycles -> gnt[0]=1 every cycle; host 1 is never granted.
- ReadLatency=3, host 0 reads at t, t+1, t+2 -> rvalid[0] at t+3, t+4, t+5 in order; busy_o high from t+1 through t+5.
- rst_i asserted one cycle after a host 1 read is accepted -> all outputs 0 immediately; no rvalid appears after reset deasserts; the first post-reset contention grants host 0.

Source files
------------

// File: rtl/sram_port_arbiter.sv
// Shares one single-port SRAM between two hosts with round-robin (or host-0 fixed)
// grant, and returns each read response to the host that issued it.
module sram_port_arbiter #(
  parameter int unsigned AddrWidth     = 11,
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned ReadLatency   = 1,
  parameter bit          Host0Priority = 1'b0
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [1:0]             h_req_i,
  input  logic [1:0]             h_we_i,
  input  logic [2*AddrWidth-1:0] h_addr_i,
  input  logic [2*DataWidth-1:0] h_wdata_i,
  input  logic [2*DataWidth-1:0] h_wmask_i,
  output logic [1:0]             h_gnt_o,
  output logic [1:0]             h_rvalid_o,
  output logic [DataWidth-1:0]   h_rdata_o,
  output logic                   ram_req_o,
  output logic                   ram_we_o,
  output logic [AddrWidth-1:0]   ram_addr_o,
  output logic [DataWidth-1:0]   ram_wdata_o,
  output logic [DataWidth-1:0]   ram_wmask_o,
  input  logic [DataWidth-1:0]   ram_rdata_i,
  output logic                   busy_o
);

  if (ReadLatency < 1 || ReadLatency > 4) begin : g_bad_latency
    $error("sram_port_arbiter: ReadLatency must be in 1..4");
  end

  logic                   ptr_q;  // 0: host 0 favoured, 1: host 1 favoured
  logic [1:0]             gnt;
  logic [ReadLatency-1:0] vld_q;
  logic [ReadLatency-1:0] own_q;
  logic                   rsp_vld;
  logic                   rsp_own;

  // Grant is held off during reset so nothing reaches the macro while it is asserted.
  always_comb begin
    gnt = 2'b00;
    if (!rst_i) begin
      unique case (h_req_i)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = (Host0Priority || !ptr_q) ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

  always_comb begin
    ram_we_o    = 1'b0;
    ram_addr_o  = '0;
    ram_wdata_o = '0;
    ram_wmask_o = '0;
    if (gnt[0]) begin
      ram_we_o    = h_we_i[0];
      ram_addr_o  = h_addr_i[AddrWidth-1:0];
      ram_wdata_o = h_wdata_i[DataWidth-1:0];
      ram_wmask_o = h_wmask_i[DataWidth-1:0];
    end else if (gnt[1]) begin
      ram_we_o    = h_we_i[1];
      ram_addr_o  = h_addr_i[2*AddrWidth-1:AddrWidth];
      ram_wdata_o = h_wdata_i[2*DataWidth-1:DataWidth];
      ram_wmask_o = h_wmask_i[2*DataWidth-1:DataWidth];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q <= 1'b0;
      vld_q <= '0;
      own_q <= '0;
    end else begin
      if (gnt[0]) begin
        ptr_q <= 1'b1;
      end else if (gnt[1]) begin
        ptr_q <= 1'b0;
      end
      vld_q[0] <= |(gnt & ~h_we_i);
      own_q[0] <= gnt[1];
      for (int i = 1; i < ReadLatency; i++) begin
        vld_q[i] <= vld_q[i-1];
        own_q[i] <= own_q[i-1];
      end
    end
  end

  // Last pipe stage lines up with the cycle the macro drives its read data.
  assign rsp_vld    = vld_q[ReadLatency-1];
  assign rsp_own    = own_q[ReadLatency-1];
  assign h_rvalid_o = {rsp_vld & rsp_own, rsp_vld & ~rsp_own};
  assign h_rdata_o  = rsp_vld ? ram_rdata_i : '0;
  assign h_gnt_o    = gnt;
  assign ram_req_o  = |gnt;
  assign busy_o     = |vld_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench: three arbiter instances (default, host-0 priority, read latency 3),
// each attached to a small behavioural SRAM model.
module tb_sram_port_arbiter;

  logic        clk;
  logic        rst;
  logic [1:0]  h_req    [3];
  logic [1:0]  h_we     [3];
  logic [21:0] h_addr   [3];
  logic [63:0] h_wdata  [3];
  logic [63:0] h_wmask  [3];
  logic [1:0]  h_gnt    [3];
  logic [1:0]  h_rvalid [3];
  logic [31:0] h_rdata  [3];
  logic        ram_req  [3];
  logic        ram_we   [3];
  logic [10:0] ram_addr [3];
  logic [31:0] ram_wdata[3];
  logic [31:0] ram_wmask[3];
  logic [31:0] ram_rdata[3];
  logic        busy     [3];
  logic        pre_we   [3];
  logic [10:0] pre_addr;
  logic [31:0] pre_data;

  int n_tests = 0;
  int n_fail  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  sram_port_arbiter u_dut0 (
    .clk_i(clk), .rst_i(rst), .h_req_i(h_req[0]), .h_we_i(h_we[0]), .h_addr_i(h_addr[0]),
    .h_wdata_i(h_wdata[0]), .h_wmask_i(h_wmask[0]), .h_gnt_o(h_gnt[0]), .h_rvalid_o(h_rvalid[0]),
    .h_rdata_o(h_rdata[0]), .ram_req_o(ram_req[0]), .ram_we_o(ram_we[0]), .ram_addr_o(ram_addr[0]),
    .ram_wdata_o(ram_wdata[0]), .ram_wmask_o(ram_wmask[0]), .ram_rdata_i(ram_rdata[0]), .busy_o(busy[0])
  );

  sram_port_arbiter #(.Host0Priority(1'b1)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .h_req_i(h_req[1]), .h_we_i(h_we[1]), .h_addr_i(h_addr[1]),
    .h_wdata_i(h_wdata[1]), .h_wmask_i(h_wmask[1]), .h_gnt_o(h_gnt[1]), .h_rvalid_o(h_rvalid[1]),
    .h_rdata_o(h_rdata[1]), .ram_req_o(ram_req[1]), .ram_we_o(ram_we[1]), .ram_addr_o(ram_addr[1]),
    .ram_wdata_o(ram_wdata[1]), .ram_wmask_o(ram_wmask[1]), .ram_rdata_i(ram_rdata[1]), .busy_o(busy[1])
  );

  sram_port_arbiter #(.ReadLatency(3)) u_dut2 (
    .clk_i(clk), .rst_i(rst), .h_req_i(h_req[2]), .h_we_i(h_we[2]), .h_addr_i(h_addr[2]),
    .h_wdata_i(h_wdata[2]), .h_wmask_i(h_wmask[2]), .h_gnt_o(h_gnt[2]), .h_rvalid_o(h_rvalid[2]),
    .h_rdata_o(h_rdata[2]), .ram_req_o(ram_req[2]), .ram_we_o(ram_we[2]), .ram_addr_o(ram_addr[2]),
    .ram_wdata_o(ram_wdata[2]), .ram_wmask_o(ram_wmask[2]), .ram_rdata_i(ram_rdata[2]), .busy_o(busy[2])
  );

  for (genvar k = 0; k < 3; k++) begin : g_ram
    localparam int Lat = (k == 2) ? 3 : 1;
    logic [31:0] mem [2048];
    logic [31:0] rdp [4];
    always @(posedge clk) begin
      if (pre_we[k]) begin
        mem[pre_addr] <= pre_data;
      end else if (ram_req[k] && ram_we[k]) begin
        mem[ram_addr[k]] <= (mem[ram_addr[k]] & ~ram_wmask[k]) | (ram_wdata[k] & ram_wmask[k]);
      end
      rdp[0] <= mem[ram_addr[k]];
      for (int i = 1; i < 4; i++) rdp[i] <= rdp[i-1];
    end
    assign ram_rdata[k] = rdp[Lat-1];
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input int k, input logic [10:0] a, input logic [31:0] d);
    pre_addr  = a;
    pre_data  = d;
    pre_we[k] = 1'b1;
    cyc();
    pre_we[k] = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      h_req[k] = 2'b00; h_we[k] = 2'b00; h_addr[k] = '0;
      h_wdata[k] = '0; h_wmask[k] = '0; pre_we[k] = 1'b0;
    end
    pre_addr = '0;
    pre_data = '0;

    preload(0, 11'h010, 32'hDEADBEEF);
    preload(0, 11'h001, 32'h11111111);
    preload(0, 11'h002, 32'h22222222);
    preload(0, 11'h7FF, 32'hAAAAAAAA);
    preload(2, 11'h020, 32'hA0A0A0A0);
    preload(2, 11'h021, 32'hB1B1B1B1);
    preload(2, 11'h022, 32'hC2C2C2C2);

    // reset state, with requests pending
    h_req[0]  = 2'b11;
    h_addr[0] = {11'h002, 11'h001};
    @(negedge clk);
    check("rst_gnt",     {62'd0, h_gnt[0]},    64'd0);
    check("rst_ram_req", {63'd0, ram_req[0]},  64'd0);
    check("rst_ram_addr",{53'd0, ram_addr[0]}, 64'd0);
    check("rst_rvalid",  {62'd0, h_rvalid[0]}, 64'd0);
    check("rst_rdata",   {32'd0, h_rdata[0]},  64'd0);
    check("rst_busy",    {63'd0, busy[0]},     64'd0);
    cyc();
    h_req[0] = 2'b00;
    rst = 1'b0;

    // single host 0 read
    h_req[0]  = 2'b01;
    h_we[0]   = 2'b00;
    h_addr[0] = {11'h000, 11'h010};
    @(negedge clk);
    check("rd0_gnt",     {62'd0, h_gnt[0]},    64'h1);
    check("rd0_ram_req", {63'd0, ram_req[0]},  64'h1);
    check("rd0_ram_addr",{53'd0, ram_addr[0]}, 64'h010);
    check("rd0_rv_early",{62'd0, h_rvalid[0]}, 64'h0);
    cyc();
    h_req[0] = 2'b00;
    @(negedge clk);
    check("rd0_rvalid",  {62'd0, h_rvalid[0]}, 64'h1);
    check("rd0_rdata",   {32'd0, h_rdata[0]},  64'hDEADBEEF);
    check("rd0_busy",    {63'd0, busy[0]},     64'h1);
    cyc();
    @(negedge clk);
    check("rd0_rv_done", {62'd0, h_rvalid[0]}, 64'h0);
    check("rd0_rd_zero", {32'd0, h_rdata[0]},  64'h0);
    check("rd0_idle",    {63'd0, busy[0]},     64'h0);
    check("idle_ramreq", {63'd0, ram_req[0]},  64'h0);
    cyc();

    // host 1 masked write then read back
    h_req[0]   = 2'b10;
    h_we[0]    = 2'b10;
    h_addr[0]  = {11'h7FF, 11'h000};
    h_wdata[0] = {32'h12345678, 32'h0};
    h_wmask[0] = {32'h0000FFFF, 32'h0};
    @(negedge clk);
    check("wr1_gnt",   {62'd0, h_gnt[0]},     64'h2);
    check("wr1_we",    {63'd0, ram_we[0]},    64'h1);
    check("wr1_addr",  {53'd0, ram_addr[0]},  64'h7FF);
    check("wr1_wdata", {32'd0, ram_wdata[0]}, 64'h12345678);
    check("wr1_wmask", {32'd0, ram_wmask[0]}, 64'h0000FFFF);
    cyc();
    h_we[0] = 2'b00;
    @(negedge clk);
    check("wr1_no_rv", {62'd0, h_rvalid[0]},  64'h0);
    check("rd1_gnt",   {62'd0, h_gnt[0]},     64'h2);
    check("rd1_we",    {63'd0, ram_we[0]},    64'h0);
    cyc();
    h_req[0]   = 2'b00;
    h_wdata[0] = '0;
    h_wmask[0] = '0;
    @(negedge clk);
    check("rd1_rvalid", {62'd0, h_rvalid[0]}, 64'h2);
    check("rd1_rdata",  {32'd0, h_rdata[0]},  64'hAAAA5678);
    cyc();

    // continuous dual reads alternate 0,1,0,1
    h_req[0]  = 2'b11;
    h_we[0]   = 2'b00;
    h_addr[0] = {11'h002, 11'h001};
    for (int i = 0; i < 5; i++) begin
      if (i == 4) h_req[0] = 2'b00;
      @(negedge clk);
      check("rr_gnt",    {62'd0, h_gnt[0]},
            (i == 4) ? 64'h0 : ((i % 2 == 1) ? 64'h2 : 64'h1));
      check("rr_rvalid", {62'd0, h_rvalid[0]},
            (i == 0) ? 64'h0 : ((i % 2 == 1) ? 64'h1 : 64'h2));
      check("rr_rdata",  {32'd0, h_rdata[0]},
            (i == 0) ? 64'h0 : ((i % 2 == 1) ? 64'h11111111 : 64'h22222222));
      cyc();
    end

    // fixed priority: host 0 always wins
    h_req[1]  = 2'b11;
    h_we[1]   = 2'b00;
    h_addr[1] = {11'h055, 11'h033};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("prio_gnt",  {62'd0, h_gnt[1]},    64'h1);
      check("prio_addr", {53'd0, ram_addr[1]}, 64'h033);
      cyc();
    end
    h_req[1] = 2'b00;

    // read latency 3, three back-to-back host 0 reads
    h_we[2] = 2'b00;
    for (int c = 0; c < 7; c++) begin
      if (c < 3) begin
        h_req[2]  = 2'b01;
        h_addr[2] = {11'h000, 11'(32'h20 + c)};
      end else begin
        h_req[2] = 2'b00;
      end
      @(negedge clk);
      check("rl3_gnt",    {62'd0, h_gnt[2]},    (c < 3) ? 64'h1 : 64'h0);
      check("rl3_busy",   {63'd0, busy[2]},     (c >= 1 && c <= 5) ? 64'h1 : 64'h0);
      check("rl3_rvalid", {62'd0, h_rvalid[2]}, (c >= 3 && c <= 5) ? 64'h1 : 64'h0);
      check("rl3_rdata",  {32'd0, h_rdata[2]},
            (c == 3) ? 64'hA0A0A0A0 : (c == 4) ? 64'hB1B1B1B1 : (c == 5) ? 64'hC2C2C2C2 : 64'h0);
      cyc();
    end

    // reset right after a host 1 read is accepted
    h_req[0]  = 2'b10;
    h_addr[0] = {11'h002, 11'h001};
    @(negedge clk);
    check("rr_gnt1", {62'd0, h_gnt[0]}, 64'h2);
    cyc();
    rst       = 1'b1;
    h_req[0]  = 2'b11;
    h_req[2]  = 2'b11;
    h_addr[2] = {11'h021, 11'h020};
    @(negedge clk);
    check("mid_rst_rvalid", {62'd0, h_rvalid[0]}, 64'h0);
    check("mid_rst_rdata",  {32'd0, h_rdata[0]},  64'h0);
    check("mid_rst_busy",   {63'd0, busy[0]},     64'h0);
    check("mid_rst_gnt",    {62'd0, h_gnt[0]},    64'h0);
    check("mid_rst_ramreq", {63'd0, ram_req[0]},  64'h0);
    cyc();
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_rv",    {62'd0, h_rvalid[0]}, 64'h0);
    check("post_rst_gnt0",  {62'd0, h_gnt[0]},    64'h1);
    check("post_rst_gnt2",  {62'd0, h_gnt[2]},    64'h1);
    cyc();
    h_req[0] = 2'b00;
    h_req[2] = 2'b00;
    @(negedge clk);
    check("post_rst_rv2",   {62'd0, h_rvalid[0]}, 64'h1);
    check("post_rst_rdata", {32'd0, h_rdata[0]},  64'h11111111);
    cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
